// File: rtl/avalon_pio_counter_master.sv
// Avalon-MM initiator: on each prescaler tick, writes an incrementing count to a PIO
// data register, reads it back and checks it. Reports count, mismatches and overruns.
module avalon_pio_counter_master #(
  parameter int unsigned TICK_DIV    = 50000000,
  parameter int unsigned COUNT_W     = 8,
  parameter int unsigned TARGET_ADDR = 0,
  parameter int unsigned ADDR_W      = 2
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               enable,
  input  logic               clr_status,
  output logic [ADDR_W-1:0]  avm_address,
  output logic               avm_write,
  output logic               avm_read,
  output logic [31:0]        avm_writedata,
  input  logic [31:0]        avm_readdata,
  input  logic               avm_waitrequest,
  output logic [COUNT_W-1:0] count,
  output logic               busy,
  output logic               err_sticky,
  output logic [7:0]         err_count,
  output logic               overrun
);

  localparam int unsigned DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(TICK_DIV - 1);
  localparam logic [ADDR_W-1:0] ADDR     = ADDR_W'(TARGET_ADDR);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WR   = 2'd1;
  localparam logic [1:0] S_RD   = 2'd2;
  localparam logic [1:0] S_CHK  = 2'd3;

  logic [DIV_W-1:0]   div_cnt;
  logic               tick;
  logic [1:0]         state;
  logic [1:0]         state_d;
  logic               pending;
  logic               pending_d;
  logic               start;
  logic               wr_acc;
  logic               rd_acc;
  logic               mismatch;
  logic [COUNT_W-1:0] count_inc;
  logic [COUNT_W-1:0] rd_cap;

  // Readback bits above the count field are deliberately ignored.
  if (COUNT_W < 32) begin : g_rd_hi
    logic unused_rd_hi;
    assign unused_rd_hi = ^avm_readdata[31:COUNT_W];
  end

  assign count_inc = count + COUNT_W'(1);
  assign mismatch  = (state == S_CHK) && (rd_cap != count);

  // Prescaler: holds while disabled, registered one-cycle tick on wrap.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      div_cnt <= '0;
      tick    <= 1'b0;
    end else begin
      tick <= 1'b0;
      if (enable) begin
        if (div_cnt == DIV_LAST) begin
          div_cnt <= '0;
          tick    <= 1'b1;
        end else begin
          div_cnt <= div_cnt + DIV_W'(1);
        end
      end
    end
  end

  // Next-state and per-cycle strobes.
  always_comb begin
    state_d = state;
    start   = 1'b0;
    wr_acc  = 1'b0;
    rd_acc  = 1'b0;
    case (state)
      S_IDLE: begin
        if (pending || tick) begin
          start   = 1'b1;
          state_d = S_WR;
        end
      end
      S_WR: begin
        if (!avm_waitrequest) begin
          wr_acc  = 1'b1;
          state_d = S_RD;
        end
      end
      S_RD: begin
        if (!avm_waitrequest) begin
          rd_acc  = 1'b1;
          state_d = S_CHK;
        end
      end
      S_CHK:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // A tick consumed directly from IDLE without a queued one never becomes pending.
  assign pending_d = (pending && !start) || (tick && !(start && !pending));

  // State register, bus command outputs and datapath.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state         <= S_IDLE;
      avm_write     <= 1'b0;
      avm_read      <= 1'b0;
      avm_address   <= '0;
      avm_writedata <= '0;
      busy          <= 1'b0;
      count         <= '0;
      rd_cap        <= '0;
    end else begin
      state         <= state_d;
      avm_write     <= (state_d == S_WR);
      avm_read      <= (state_d == S_RD);
      avm_address   <= ((state_d == S_WR) || (state_d == S_RD)) ? ADDR : '0;
      avm_writedata <= (state_d == S_WR) ? 32'(count_inc) : 32'd0;
      busy          <= (state_d != S_IDLE);
      if (wr_acc) count  <= count_inc;
      if (rd_acc) rd_cap <= avm_readdata[COUNT_W-1:0];
    end
  end

  // Pending tick and status; clr_status overrides any same-cycle set.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pending    <= 1'b0;
      overrun    <= 1'b0;
      err_sticky <= 1'b0;
      err_count  <= 8'd0;
    end else begin
      pending <= pending_d;
      if (clr_status) begin
        overrun    <= 1'b0;
        err_sticky <= 1'b0;
        err_count  <= 8'd0;
      end else begin
        if (tick && pending) overrun <= 1'b1;
        if (mismatch) begin
          err_sticky <= 1'b1;
          if (err_count != 8'hFF) err_count <= err_count + 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_avalon_pio_counter_master.sv
// Bench for avalon_pio_counter_master: directed steps plus randomized waitrequest and
// readback corruption, checked against a transaction-level model of the count sequence.
module tb_avalon_pio_counter_master;

  localparam int unsigned CW    = 4;
  localparam int unsigned TADDR = 2;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        enable;
  logic        clr_status;
  logic [1:0]  avm_address;
  logic        avm_write;
  logic        avm_read;
  logic [31:0] avm_writedata;
  logic [31:0] avm_readdata;
  logic        avm_waitrequest;
  logic [CW-1:0] count;
  logic        busy;
  logic        err_sticky;
  logic [7:0]  err_count;
  logic        overrun;

  logic        force_wait = 1'b0;
  logic        rand_wait  = 1'b0;
  logic [1:0]  rd_mode    = 2'd0;
  logic        rnd_wait   = 1'b0;
  logic        rnd_corrupt = 1'b0;
  logic [31:0] rnd_upper  = 32'd0;
  logic [CW-1:0] slave_reg = '0;

  int n_tests = 0;
  int n_fail  = 0;

  // Monitor / model state.
  int          viol       = 0;
  int          wr_acc_cnt = 0;
  int          rd_acc_cnt = 0;
  int          model_err  = 0;
  logic [CW-1:0] model_count = '0;
  logic        stall_wr = 1'b0;
  logic        stall_rd = 1'b0;
  logic [31:0] stall_wd = 32'd0;

  always #5 clk = ~clk;

  avalon_pio_counter_master #(
    .TICK_DIV(4), .COUNT_W(CW), .TARGET_ADDR(TADDR), .ADDR_W(2)
  ) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .clr_status(clr_status),
    .avm_address(avm_address), .avm_write(avm_write), .avm_read(avm_read),
    .avm_writedata(avm_writedata), .avm_readdata(avm_readdata),
    .avm_waitrequest(avm_waitrequest), .count(count), .busy(busy),
    .err_sticky(err_sticky), .err_count(err_count), .overrun(overrun)
  );

  // Slave: PIO data register plus selectable readback behaviour.
  assign avm_waitrequest = force_wait | (rand_wait & rnd_wait);

  always @(posedge clk) begin
    rnd_wait    <= ($urandom_range(0, 1) == 1);
    rnd_corrupt <= ($urandom_range(0, 3) == 0);
    rnd_upper   <= $urandom;
    if (avm_write && !avm_waitrequest) slave_reg <= avm_writedata[CW-1:0];
  end

  always_comb begin
    case (rd_mode)
      2'd0:    avm_readdata = {28'h0, slave_reg};
      2'd1:    avm_readdata = 32'h0000_0055;
      2'd2:    avm_readdata = {rnd_upper[31:4], slave_reg ^ {3'b000, rnd_corrupt}};
      default: avm_readdata = {28'hABCDEF0, ~slave_reg};
    endcase
  end

  // Transaction model: writes must carry last+1 mod 2^CW; every accepted read whose
  // low bits differ from the last written value is one (saturating) error.
  always @(negedge clk) begin : mon
    int v;
    int e;
    logic [CW-1:0] exp_wd;
    v      = 0;
    e      = model_err;
    exp_wd = model_count + 4'd1;
    if (!reset_n) begin
      model_count <= '0;
      model_err   <= 0;
      stall_wr    <= 1'b0;
      stall_rd    <= 1'b0;
    end else begin
      if (clr_status) e = 0;
      if (avm_write && avm_read) v++;
      if ((avm_write || avm_read) && (avm_address != 2'(TADDR))) v++;
      if (stall_wr && !(avm_write && (avm_writedata == stall_wd))) v++;
      if (stall_rd && !avm_read) v++;
      if (avm_write && !avm_waitrequest) begin
        if (avm_writedata !== 32'(exp_wd)) v++;
        model_count <= exp_wd;
        wr_acc_cnt  <= wr_acc_cnt + 1;
      end
      if (avm_read && !avm_waitrequest) begin
        if ((avm_readdata[CW-1:0] != model_count) && (e < 255)) e++;
        rd_acc_cnt <= rd_acc_cnt + 1;
      end
      stall_wr  <= avm_write && avm_waitrequest;
      stall_rd  <= avm_read && avm_waitrequest;
      stall_wd  <= avm_writedata;
      viol      <= viol + v;
      model_err <= e;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_write(input int budget, output int cycles, output bit ok);
    ok = 1'b0;
    cycles = 0;
    for (int i = 1; i <= budget; i++) begin
      step(1);
      if (avm_write) begin
        ok = 1'b1;
        cycles = i;
        break;
      end
    end
  endtask

  task automatic wait_quiet(input int n, input int budget, output bit ok);
    int run;
    run = 0;
    ok  = 1'b0;
    for (int i = 0; i < budget; i++) begin
      step(1);
      if (!busy && !avm_write && !avm_read) run++;
      else run = 0;
      if (run >= n) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int  cyc;
    bit  ok;
    int  base;
    logic [31:0] wd0;
    logic [1:0]  ad0;

    reset_n = 1'b0; enable = 1'b0; clr_status = 1'b0;
    step(3);
    reset_n = 1'b1;

    // Reset and idle with enable low.
    for (int i = 0; i < 20; i++) begin
      step(1);
      check("idle_cmd", {30'd0, avm_write, avm_read}, 32'd0);
    end
    check("idle_count", 32'(count), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_status", {22'd0, err_sticky, overrun, err_count}, 32'd0);
    check("idle_wdata", avm_writedata, 32'd0);

    // Basic write/readback and first-write latency.
    enable = 1'b1;
    wait_write(50, cyc, ok);
    check("first_wr_found", 32'(ok), 32'd1);
    check("first_wr_latency", 32'(cyc), 32'd5);
    check("first_wr_data", avm_writedata, 32'd1);
    check("first_wr_addr", 32'(avm_address), 32'(TADDR));
    step(1);
    check("first_rd_cmd", {30'd0, avm_write, avm_read}, 32'd1);
    check("first_count", 32'(count), 32'd1);
    step(1);
    check("chk_busy", 32'(busy), 32'd1);
    check("chk_no_cmd", {30'd0, avm_write, avm_read}, 32'd0);
    step(1);
    check("back_idle", 32'(busy), 32'd0);
    check("first_no_err", 32'(err_sticky), 32'd0);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      step(1);
      if (count == 4'd4) begin ok = 1'b1; break; end
    end
    enable = 1'b0;
    check("reach_count4", 32'(ok), 32'd1);
    wait_quiet(6, 100, ok);
    check("quiet_after4", 32'(ok), 32'd1);
    check("four_ticks_status", {22'd0, err_sticky, overrun, err_count}, 32'd0);

    // Waitrequest stall: write held 4 cycles, read held 3 cycles.
    force_wait = 1'b1;
    enable     = 1'b1;
    wait_write(50, cyc, ok);
    enable = 1'b0;
    check("stall_wr_found", 32'(ok), 32'd1);
    wd0 = avm_writedata;
    ad0 = avm_address;
    check("stall_wd", wd0, 32'd5);
    for (int i = 0; i < 3; i++) begin
      step(1);
      check("stall_wr_held", {30'd0, avm_write, avm_read}, 32'd2);
      check("stall_wd_stable", avm_writedata, wd0);
      check("stall_addr_stable", 32'(avm_address), 32'(ad0));
    end
    force_wait = 1'b0;
    step(1);
    force_wait = 1'b1;
    check("stall_rd_start", {30'd0, avm_write, avm_read}, 32'd1);
    check("stall_count", 32'(count), 32'd5);
    step(1);
    check("stall_rd_held1", 32'(avm_read), 32'd1);
    step(1);
    check("stall_rd_held2", 32'(avm_read), 32'd1);
    force_wait = 1'b0;
    step(1);
    check("stall_rd_done", 32'(avm_read), 32'd0);
    wait_quiet(6, 100, ok);
    check("stall_no_err", {22'd0, err_sticky, overrun, err_count}, 32'd0);

    // Single mismatch, then clear.
    rd_mode = 2'd1;
    enable  = 1'b1;
    wait_write(50, cyc, ok);
    enable = 1'b0;
    wait_quiet(6, 100, ok);
    rd_mode = 2'd0;
    check("mm_count", 32'(count), 32'd6);
    check("mm_sticky", 32'(err_sticky), 32'd1);
    check("mm_errcnt", 32'(err_count), 32'd1);
    clr_status = 1'b1;
    step(1);
    clr_status = 1'b0;
    step(1);
    check("clr_status", {22'd0, err_sticky, overrun, err_count}, 32'd0);

    // 300 mismatching readbacks: err_count saturates.
    rd_mode = 2'd3;
    base    = rd_acc_cnt;
    enable  = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      step(1);
      if (rd_acc_cnt >= base + 300) begin ok = 1'b1; break; end
    end
    enable = 1'b0;
    check("sat_reads_done", 32'(ok), 32'd1);
    wait_quiet(6, 100, ok);
    rd_mode = 2'd0;
    check("sat_errcnt", 32'(err_count), 32'd255);
    check("sat_model", 32'(err_count), 32'(model_err));
    check("sat_sticky", 32'(err_sticky), 32'd1);
    check("sat_no_overrun", 32'(overrun), 32'd0);
    check("sat_count_model", 32'(count), 32'(model_count));
    clr_status = 1'b1;
    step(1);
    clr_status = 1'b0;
    step(1);
    check("sat_clr", {22'd0, err_sticky, overrun, err_count}, 32'd0);

    // Overrun: long stall queues one tick, second tick flags overrun.
    force_wait = 1'b1;
    enable     = 1'b1;
    wait_write(50, cyc, ok);
    check("ovr_wr_found", 32'(ok), 32'd1);
    step(4);
    check("ovr_not_yet", 32'(overrun), 32'd0);
    step(4);
    enable = 1'b0;
    check("ovr_set", 32'(overrun), 32'd1);
    check("ovr_wr_held", 32'(avm_write), 32'd1);
    step(2);
    force_wait = 1'b0;
    base = wr_acc_cnt;
    wait_quiet(8, 200, ok);
    check("ovr_quiet", 32'(ok), 32'd1);
    check("ovr_one_queued", 32'(wr_acc_cnt - base), 32'd2);
    check("ovr_sticky", 32'(overrun), 32'd1);
    check("ovr_no_err", 32'(err_sticky), 32'd0);
    clr_status = 1'b1;
    step(1);
    clr_status = 1'b0;
    step(1);
    check("ovr_clr", 32'(overrun), 32'd0);

    // Count wrap: write after 15 carries 0 and checks clean.
    enable = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      step(1);
      if (avm_write && (count == 4'hF)) begin ok = 1'b1; break; end
    end
    enable = 1'b0;
    check("wrap_found", 32'(ok), 32'd1);
    check("wrap_wdata", avm_writedata, 32'd0);
    wait_quiet(6, 100, ok);
    check("wrap_count", 32'(count), 32'd0);
    check("wrap_no_err", {22'd0, err_sticky, overrun, err_count}, 32'd0);

    // Reset in the middle of a stalled write.
    force_wait = 1'b1;
    enable     = 1'b1;
    wait_write(50, cyc, ok);
    check("rst_wr_found", 32'(ok), 32'd1);
    reset_n = 1'b0;
    step(1);
    check("rst_drop_wr", {30'd0, avm_write, avm_read}, 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_wdata", avm_writedata, 32'd0);
    reset_n    = 1'b1;
    force_wait = 1'b0;
    enable     = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      check("rst_stays_idle", {29'd0, busy, avm_write, avm_read}, 32'd0);
    end

    // Randomized waitrequest, corruption and upper readdata bits.
    rand_wait = 1'b1;
    rd_mode   = 2'd2;
    base      = wr_acc_cnt;
    enable    = 1'b1;
    step(2000);
    enable = 1'b0;
    wait_quiet(8, 500, ok);
    check("rand_quiet", 32'(ok), 32'd1);
    check("rand_activity", 32'(wr_acc_cnt - base > 100), 32'd1);
    check("rand_count", 32'(count), 32'(model_count));
    check("rand_errcnt", 32'(err_count), 32'(model_err));
    check("rand_sticky", 32'(err_sticky), 32'(model_err != 0));
    check("protocol_violations", 32'(viol), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
